// File: rtl/baudot_pkg.sv
// Shared ITA2 Baudot definitions.
// Used by the serial receiver and by the downstream Baudot-to-ASCII converter.
// It provides the shift-code constants, the receiver state encoding and a
// shift-code helper.
package baudot_pkg;

    localparam logic [4:0] ITA2_LTRS = 5'b11111;
    localparam logic [4:0] ITA2_FIGS = 5'b11011;

    typedef enum logic [2:0] {
        WAIT_MARK,
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    // True for the two codes that only change the shift state.
    function automatic logic is_shift_code(input logic [4:0] c);
        return (c == ITA2_LTRS) || (c == ITA2_FIGS);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer. Both flops reset to all ones (line mark).
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset
//   d_i    - asynchronous input
//   q_o    - synchronized output, two clk_i edges behind d_i
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/baudot_rx.sv
// Oversampling ITA2 Baudot receiver.
// Each frame is 1 start bit (0), 5 data bits sent LSB first, and a stop bit (1).
// The receiver tracks the LTRS/FIGS shift state. Each printable code is
// delivered with its shift flag over a valid/ready handshake.
// Ports:
//   clk_baudot   - clock, OVERSAMPLE x baud
//   rst_n        - asynchronous active-low reset
//   baudot_input - raw line, idle mark (1)
//   code         - received code, bit0 = first data bit
//   code_figs    - shift state captured with code (1 = FIGS)
//   code_valid   - code/code_figs valid, held until accepted
//   code_ready   - consumer accept
//   frame_err    - 1-cycle pulse, stop bit sampled low
//   overrun      - 1-cycle pulse, character dropped because buffer full
//   busy         - a frame is in progress
module baudot_rx
    import baudot_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 6
) (
    input  logic       clk_baudot,
    input  logic       rst_n,
    input  logic       baudot_input,
    output logic [4:0] code,
    output logic       code_figs,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);

    logic rx_s;

    sync_2ff #(.WIDTH(1)) u_sync (
        .clk_i  (clk_baudot),
        .rst_ni (rst_n),
        .d_i    (baudot_input),
        .q_o    (rx_s)
    );

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [4:0]       shreg_q, shreg_d;
    logic             figs_q, figs_d;
    logic [4:0]       code_q, code_d;
    logic             code_figs_q, code_figs_d;
    logic             code_valid_q, code_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic [1:0]       flush_q, flush_d;

    // The synchronizer comes out of reset showing mark. flush_q waits until
    // the real line value has reached rx_s. Without it, a line held low
    // through reset would look like mark followed by a start edge.
    logic sync_ok;
    assign sync_ok = flush_q[1];

    always_ff @(posedge clk_baudot or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_MARK;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            figs_q       <= 1'b0;
            code_q       <= '0;
            code_figs_q  <= 1'b0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            flush_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            figs_q       <= figs_d;
            code_q       <= code_d;
            code_figs_q  <= code_figs_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            flush_q      <= flush_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        figs_d       = figs_q;
        code_d       = code_q;
        code_figs_d  = code_figs_q;
        code_valid_d = code_valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        flush_d      = {flush_q[0], 1'b1};

        // Accept. A delivery on the same edge sets valid again below.
        if (code_valid_q && code_ready) begin
            code_valid_d = 1'b0;
        end

        unique case (state_q)
            WAIT_MARK: begin
                if (sync_ok && rx_s) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            START: begin
                if (cnt_q == CNT_HALF) begin
                    if (!rx_s) begin
                        state_d   = DATA;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;   // glitch, too short to be a start bit
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    // LSB-first: after five right-shifts the first bit is in bit0.
                    shreg_d = {rx_s, shreg_q[4:1]};
                    if (bit_idx_q == 3'd4) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                        if (is_shift_code(shreg_q)) begin
                            figs_d = (shreg_q == ITA2_FIGS);
                        end else if (!code_valid_q || code_ready) begin
                            code_d       = shreg_q;
                            code_figs_d  = figs_q;
                            code_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_MARK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = WAIT_MARK;
            end
        endcase
    end

    assign code       = code_q;
    assign code_figs  = code_figs_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE) && (state_q != WAIT_MARK);

endmodule

// File: doc/baudot_rx.md
Name: baudot_rx

Overview:
- Oversampling serial receiver for 5-bit ITA2 Baudot frames arriving on the teletype line.
- Frame format: 1 start bit (space/0), 5 data bits LSB-first, then stop (mark/1).
- Tracks the LTRS/FIGS shift state and delivers each printable code with its shift flag over a valid/ready handshake.
- Sits directly upstream of the Baudot-to-ASCII converter and feeds it decoded characters instead of the raw line.

Parameters:
- OVERSAMPLE, 16, clk_baudot cycles per bit; even, 4..64.
- CNT_W, 6, counter width; must satisfy 2^CNT_W >= OVERSAMPLE.

Ports:
- clk_baudot  in  1  single clock, OVERSAMPLE x baud.
- rst_n  in  1  asynchronous, active-low reset.
- baudot_input  in  1  raw async line; idle = 1 (mark).
- code  out  5  received ITA2 code, bit0 = first data bit.
- code_figs  out  1  shift state latched with code (1 = FIGS).
- code_valid  out  1  code/code_figs are valid.
- code_ready  in  1  consumer accepts when code_valid && code_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: new character dropped because buffer full.
- busy  out  1  state is neither IDLE nor WAIT_MARK.

Behaviour:
- Synchronizer: 2 flops on baudot_input, both reset to 1; the output is rx_s.
- Reset values: state = WAIT_MARK, figs = 0, cnt = 0, bit_idx = 0; all outputs 0.
- Reset is asynchronous at any point, including mid-frame; the partial frame is discarded.
- WAIT_MARK: go to IDLE on the first cycle with rx_s = 1. Prevents a line held low through reset from being taken as a start bit.
- IDLE: rx_s = 0 -> START with cnt = 0.
- START: cnt increments each cycle. When cnt = OVERSAMPLE/2-1, sample rx_s:
  - 0 -> DATA, cnt = 0, bit_idx = 0.
  - 1 -> IDLE (glitch rejected; no pulse, no state change).
- DATA: when cnt = OVERSAMPLE-1, shift rx_s into shreg[bit_idx] and set cnt = 0. After bit_idx 4, go to STOP.
- STOP: when cnt = OVERSAMPLE-1, sample rx_s:
  - 1 -> deliver; go to IDLE the same edge. The 0.5 extra stop bit is absorbed by IDLE.
  - 0 -> frame_err pulse; go to WAIT_MARK; nothing delivered.
- Timing from E0 (first edge the first synchronizer flop captures 0):
  - IDLE->START at E2.
  - Start sampled at E2+OVERSAMPLE/2.
  - Data bit i sampled at E2+OVERSAMPLE/2+(i+1)*OVERSAMPLE.
  - Stop sampled at E2+OVERSAMPLE/2+6*OVERSAMPLE.
  - code_valid / frame_err visible after that edge. With OVERSAMPLE = 16, that is edge E0+106.
- Deliver rules:
  - shreg = 5'b11111 (LTRS): figs <= 0; not delivered; never causes overrun.
  - shreg = 5'b11011 (FIGS): figs <= 1; not delivered; never causes overrun.
  - Any other code, including 5'b00000: if the buffer is free, load code = shreg, code_figs = figs, code_valid = 1.
  - A shift code received while a character is buffered does not alter that character's code_figs.
- Handshake:
  - code, code_figs and code_valid stay stable until code_valid && code_ready.
  - code_valid clears on the edge after acceptance unless a new code loads on that same edge.
  - Accept and deliver on the same edge: the new code loads, no overrun.
  - Deliver while code_valid && !code_ready: the new code is dropped, overrun pulses one cycle, and the old code is held.
- Pulses are exactly one cycle wide; frame_err and overrun never assert together.

Decomposition:
- Package baudot_pkg:
  - ITA2_LTRS = 5'b11111, ITA2_FIGS = 5'b11011.
  - State enum {WAIT_MARK, IDLE, START, DATA, STOP}.
  - Shared with the converter for its shift handling.
- Sub-module sync_2ff: generic 2-flop synchronizer with reset value 1, reusable on the converter's clk_ascii side.

Test Plan (OVERSAMPLE = 16; each bit held 16 cycles; line idle 1):
- Reset, line high, send code 5'h03 (bits 1,1,0,0,0) with code_ready = 1 -> code_valid high after E0+106 for exactly 1 cycle; code = 5'h03; code_figs = 0; no pulses.
- Send FIGS, then 5'h03, then LTRS, then 5'h03 -> exactly two deliveries, both 5'h03, with code_figs = 1 then code_figs = 0; shift codes produce no code_valid.
- Line low for 4 cycles, then high -> busy high for about 8 cycles then 0; no code_valid, no frame_err; figs unchanged.
- Send 5'h03 with stop held low for 48 cycles -> frame_err pulse at E0+106; no code_valid; a new start edge inside the low period is ignored; the next valid frame after the line returns high is received normally.
- code_ready = 0; send 5'h03, then 5'h0A, then FIGS -> code = 5'h03 held; one overrun pulse at the second frame's stop edge; none for FIGS. Then raise code_ready -> 5'h03 accepted and code_valid drops; a later 5'h0A frame is delivered with code_figs = 1.
- Assert rst_n = 0 during data bit 3 while the line is low -> all outputs 0 immediately. Release with the line still low -> no start until the line goes high then low again; the next frame decodes correctly.
